// File: rtl/lsu_mem_stage.sv
`default_nettype none
// =============================================================================
// Module  : lsu_mem_stage
// Purpose : RV32I memory-stage LSU. Drives a req/gnt/rvalid data bus and returns
//           lane-aligned, extended load data. Macro LSU_MISALIGN_TRAP_EN enables
//           misalignment traps and a RESP_LAT_MAX response timeout.
// Rev     : 1.0
// =============================================================================
module lsu_mem_stage #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned RESP_LAT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       mem_data,
  output logic              mem_valid,
  output logic              fault,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  if ((RESP_LAT_MAX < 1) || (ADDR_W < 3) || (ADDR_W > 32)) begin : g_cfg_check
    $error("lsu_mem_stage: unsupported RESP_LAT_MAX/ADDR_W configuration");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       mem_data_q;

  logic        new_op, is_b, is_h, trap_d, go_bus, timeout;
  logic [1:0]  off, off_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, lane, load_d;

  assign new_op = ex_valid & (mem_read | mem_write);

  // Funct3 low bits pick the size; 011/110/111 fall through to word.
  always_comb begin
    off     = alu_result[1:0];
    is_b    = (funct3[1:0] == 2'b00);
    is_h    = (funct3[1:0] == 2'b01);
    off_d   = 2'b00;
    wstrb_d = 4'b1111;
    wdata_d = store_data;
    if (is_b) begin
      off_d   = off;
      wstrb_d = 4'b0001 << off;
      wdata_d = {4{store_data[7:0]}};
    end else if (is_h) begin
      off_d   = {off[1], 1'b0};
      wstrb_d = 4'b0011 << off_d;
      wdata_d = {2{store_data[15:0]}};
    end
    if (!mem_write) begin
      wstrb_d = 4'b0000;
    end
  end

  always_comb begin
    lane   = dmem_rdata >> {off_q, 3'b000};
    load_d = lane;
    if (funct3_q[1:0] == 2'b00) begin
      load_d = {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
    end else if (funct3_q[1:0] == 2'b01) begin
      load_d = {{16{~funct3_q[2] & lane[15]}}, lane[15:0]};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  localparam int unsigned CNT_W = $clog2(RESP_LAT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  assign trap_d  = is_h ? off[0] : (!is_b && (off != 2'b00));
  assign timeout = (state_q == S_RESP) && !dmem_rvalid &&
                   (cnt_q == CNT_W'(RESP_LAT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= (state_q == S_RESP) ? cnt_q + 1'b1 : '0;
      fault_q <= ((state_q == S_IDLE) && new_op && trap_d) || timeout;
    end
  end

  assign fault = fault_q;
`else
  assign trap_d  = 1'b0;
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  assign go_bus = new_op & ~trap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      mem_data_q <= 32'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go_bus) begin
            state_q  <= S_REQ;
            addr_q   <= {alu_result[ADDR_W-1:2], 2'b00};
            funct3_q <= funct3;
            off_q    <= off_d;
            we_q     <= mem_write;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
          end else if (new_op) begin
            state_q <= S_DONE;  // trapped misaligned op: no bus traffic
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            if (dmem_rvalid) begin
              state_q <= S_DONE;
              if (!we_q) begin
                mem_data_q <= load_d;
              end
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            state_q <= S_DONE;
            if (!we_q) begin
              mem_data_q <= load_d;
            end
          end else if (timeout) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall      = (state_q == S_REQ) || (state_q == S_RESP) ||
                      ((state_q == S_IDLE) && new_op);
  assign mem_valid  = (state_q == S_DONE);
  assign mem_data   = mem_data_q;
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// tb_lsu_mem_stage : randomized bench for lsu_mem_stage against a byte-lane
// reference model; trap/timeout scenarios run when LSU_MISALIGN_TRAP_EN is set.
module tb_lsu_mem_stage;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LAT_MAX = 16;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        stall, mem_valid, fault, dmem_req, dmem_we;
  logic [31:0] mem_data, dmem_wdata, dmem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_md = 32'h0;

  lsu_mem_stage #(.ADDR_W(ADDR_W), .RESP_LAT_MAX(LAT_MAX)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .stall(stall), .mem_data(mem_data),
    .mem_valid(mem_valid), .fault(fault), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % op_size(f3)) != 0;
  endfunction

  function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % op_size(f3));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rw);
    logic [31:0] v;
    v = rw >> (8 * eff_off(f3, a));
    if (op_size(f3) == 1) begin
      v = v & 32'h0000_00FF;
      if ((f3 == 3'b000) && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op_size(f3) == 2) begin
      v = v & 32'h0000_FFFF;
      if ((f3 == 3'b001) && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int eo, sz;
    eo = eff_off(f3, a);
    sz = op_size(f3);
    s  = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= eo) && (i < eo + sz);
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = op_size(f3);
    w  = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic int exp_done(input bit mis, input int gd, input int rdl);
    if (TRAP && mis) return 1;
    if (TRAP && (rdl > int'(LAT_MAX))) return 2 + gd + int'(LAT_MAX);
    return 2 + gd + rdl;
  endfunction

  // Drives one op with grant after gd REQ cycles and rvalid rdl cycles after grant;
  // records what the DUT showed. Cycle 0 is the IDLE cycle presenting the op.
  task automatic run_op(
    input  bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
    input  logic [31:0] sd, input logic [31:0] rw, input int gd, input int rdl,
    input  int done_c,
    output int vcyc, output int vcnt, output int fcnt,
    output logic [31:0] smask, output logic [31:0] rmask, output logic [31:0] md,
    output logic [31:0] baddr, output logic bwe, output logic [31:0] bwd,
    output logic [3:0] bstrb, output bit unstable);
    int unsigned r;
    vcyc = -1; vcnt = 0; fcnt = 0; smask = '0; rmask = '0; md = '0;
    baddr = '0; bwe = 1'b0; bwd = '0; bstrb = '0; unstable = 1'b0;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = a; store_data = sd;
      end else if (c < done_c) begin
        r = $urandom_range(2);
        ex_valid   = 1'($urandom_range(1));
        mem_read   = (r == 1);
        mem_write  = (r == 2);
        funct3     = 3'($urandom);
        alu_result = $urandom;
        store_data = $urandom;
      end else begin
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      end
      dmem_gnt    = (c == 1 + gd);
      dmem_rvalid = (c == 1 + gd + rdl);
      dmem_rdata  = (c == 1 + gd + rdl) ? rw : $urandom;
      @(negedge clk);
      if (stall) smask[c] = 1'b1;
      if (dmem_req) begin
        rmask[c] = 1'b1;
        if (rmask == (32'd1 << c)) begin
          baddr = dmem_addr; bwe = dmem_we; bwd = dmem_wdata; bstrb = dmem_wstrb;
        end else if ((dmem_addr !== baddr) || (dmem_we !== bwe) ||
                     (dmem_wdata !== bwd) || (dmem_wstrb !== bstrb)) begin
          unstable = 1'b1;
        end
      end
      if (fault) fcnt++;
      if (mem_valid) begin
        vcnt++;
        if (vcyc < 0) begin
          vcyc = c;
          md   = mem_data;
        end
      end
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    alu_result = '0; store_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", mem_data); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", dmem_we); end
    checks++; if (dmem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
    checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", dmem_wdata); end
    checks++; if (dmem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %b want 0", dmem_wstrb); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_plan_loads();
    int vc, vn, fc; logic [31:0] sm, rm, md, ba, wd; logic we; logic [3:0] st; bit un;
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0, 1, 3,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (vc !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", vc); end
    checks++; if (md !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", md); end
    checks++; if (sm !== 32'h7) begin errors++; $display("FAIL lb_stall: got %h want 7", sm); end
    checks++; if (vn !== 1) begin errors++; $display("FAIL lb_valid_pulses: got %0d want 1", vn); end
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 0, 1, 3,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (md !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", md); end
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0, 1, 3,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (md !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", md); end
    model_md = 32'hFFFF_8001;
  endtask

  task automatic test_store();
    int vc, vn, fc; logic [31:0] sm, rm, md, ba, wd; logic we; logic [3:0] st; bit un;
    run_op(0, 1, 3'b000, 32'h201, 32'h1234_56AB, $urandom, 0, 1, 3,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (ba !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", ba); end
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL sb_wstrb: got %b want 0010", st); end
    checks++; if (wd !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", wd); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", we); end
    checks++; if (md !== model_md) begin errors++; $display("FAIL sb_mem_data: got %h want %h", md, model_md); end
    checks++; if (vc !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", vc); end
  endtask

  task automatic test_grant_delay();
    int vc, vn, fc; logic [31:0] sm, rm, md, ba, wd, rw; logic we; logic [3:0] st; bit un;
    run_op(0, 1, 3'b001, 32'h346, 32'hCAFE_BEEF, $urandom, 4, 1, 7,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (un !== 1'b0) begin errors++; $display("FAIL gnt_delay_stable: bus changed during REQ"); end
    checks++; if (rm !== 32'h3E) begin errors++; $display("FAIL gnt_delay_req: got %h want 0000003e", rm); end
    checks++; if ((ba !== 32'h344) || (st !== 4'b1100) || (wd !== 32'hBEEF_BEEF)) begin
      errors++; $display("FAIL gnt_delay_bus: got addr=%h strb=%b wdata=%h want 00000344 1100 beefbeef", ba, st, wd);
    end
    checks++; if (vc !== 7) begin errors++; $display("FAIL gnt_delay_latency: got %0d want 7", vc); end
    rw = $urandom;
    run_op(1, 0, 3'b010, 32'h500, 32'h0, rw, 2, 0, 4,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (vc !== 4) begin errors++; $display("FAIL gnt_rvalid_same_latency: got %0d want 4", vc); end
    checks++; if (md !== rw) begin errors++; $display("FAIL gnt_rvalid_same_data: got %h want %h", md, rw); end
    model_md = rw;
  endtask

  task automatic test_random();
    int vc, vn, fc, gd, rdl, dc; logic [31:0] sm, rm, md, ba, wd, a, sd, rw, esm, erm;
    logic we; logic [3:0] st; logic [2:0] f3; bit un, rd, wr, trap;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom); a = $urandom; sd = $urandom; rw = $urandom;
      wr = 1'($urandom_range(1)); rd = !wr;
      gd = $urandom_range(3); rdl = $urandom_range(3);
      trap = TRAP && is_misaligned(f3, a);
      dc = exp_done(is_misaligned(f3, a), gd, rdl);
      run_op(rd, wr, f3, a, sd, rw, gd, rdl, dc,
             vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
      if (rd && !trap) model_md = ref_load(f3, a, rw);
      esm = '0; erm = '0;
      for (int i = 0; i < dc; i++) esm[i] = 1'b1;
      if (!trap) for (int i = 1; i <= 1 + gd; i++) erm[i] = 1'b1;
      checks++; if ((vc !== dc) || (vn !== 1)) begin
        errors++; $display("FAIL rnd_valid[%0d]: got cycle=%0d pulses=%0d want cycle=%0d pulses=1", n, vc, vn, dc);
      end
      checks++; if (md !== model_md) begin
        errors++; $display("FAIL rnd_mem_data[%0d]: f3=%b a=%h rd=%h got %h want %h", n, f3, a, rw, md, model_md);
      end
      checks++; if (fc !== (trap ? 1 : 0)) begin
        errors++; $display("FAIL rnd_fault[%0d]: got %0d want %0d", n, fc, trap ? 1 : 0);
      end
      checks++; if (rm !== erm) begin errors++; $display("FAIL rnd_req[%0d]: got %h want %h", n, rm, erm); end
      checks++; if (sm !== esm) begin errors++; $display("FAIL rnd_stall[%0d]: got %h want %h", n, sm, esm); end
      checks++; if (un !== 1'b0) begin errors++; $display("FAIL rnd_stable[%0d]: bus changed during REQ", n); end
      if (!trap) begin
        checks++; if ((ba !== {a[31:2], 2'b00}) || (we !== wr)) begin
          errors++; $display("FAIL rnd_addr_we[%0d]: got %h/%b want %h/%b", n, ba, we, {a[31:2], 2'b00}, wr);
        end
        if (wr) begin
          checks++; if ((st !== ref_strb(f3, a)) || (wd !== ref_wdata(f3, sd))) begin
            errors++; $display("FAIL rnd_store_lanes[%0d]: f3=%b a=%h got %b/%h want %b/%h",
                               n, f3, a, st, wd, ref_strb(f3, a), ref_wdata(f3, sd));
          end
        end
      end
    end
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_trap();
    int vc, vn, fc; logic [31:0] sm, rm, md, ba, wd, rw; logic we; logic [3:0] st; bit un;
    run_op(1, 0, 3'b010, 32'h102, 32'h0, $urandom, 0, 1, 1,
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if (rm !== 32'h0) begin errors++; $display("FAIL trap_no_req: got %h want 0", rm); end
    checks++; if ((vc !== 1) || (fc !== 1)) begin
      errors++; $display("FAIL trap_pulse: got valid@%0d faults=%0d want valid@1 faults=1", vc, fc);
    end
    checks++; if (md !== model_md) begin errors++; $display("FAIL trap_mem_data: got %h want %h", md, model_md); end
    run_op(1, 0, 3'b010, 32'h100, 32'h0, $urandom, 0, 100, 2 + int'(LAT_MAX),
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if ((vc !== 2 + int'(LAT_MAX)) || (fc !== 1)) begin
      errors++; $display("FAIL timeout: got valid@%0d faults=%0d want valid@%0d faults=1", vc, fc, 2 + LAT_MAX);
    end
    checks++; if (md !== model_md) begin errors++; $display("FAIL timeout_mem_data: got %h want %h", md, model_md); end
    rw = $urandom;
    run_op(1, 0, 3'b010, 32'h104, 32'h0, rw, 0, int'(LAT_MAX), 2 + int'(LAT_MAX),
           vc, vn, fc, sm, rm, md, ba, we, wd, st, un);
    checks++; if ((fc !== 0) || (md !== rw)) begin
      errors++; $display("FAIL late_rvalid_edge: got faults=%0d data=%h want 0 %h", fc, md, rw);
    end
    model_md = rw;
  endtask
`endif

  task automatic test_reset_mid();
    int vn = 0, fn = 0, busy = 0;
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h480; store_data = $urandom;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b want 1", dmem_req); end
    @(posedge clk); #1;
    dmem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_resp_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if ({stall, mem_valid, fault, dmem_req, dmem_we} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got stall/valid/fault/req/we=%b want 00000",
                         {stall, mem_valid, fault, dmem_req, dmem_we});
    end
    checks++; if ((mem_data !== 32'h0) || (dmem_addr !== '0) || (dmem_wdata !== 32'h0) || (dmem_wstrb !== 4'h0)) begin
      errors++; $display("FAIL rst_mid_data: got md=%h addr=%h wd=%h strb=%b want all 0",
                         mem_data, dmem_addr, dmem_wdata, dmem_wstrb);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      if (mem_valid) vn++;
      if (fault) fn++;
      if (stall || dmem_req) busy++;
    end
    checks++; if ((vn !== 0) || (fn !== 0) || (busy !== 0)) begin
      errors++; $display("FAIL rst_mid_after: got valid=%0d fault=%0d busy=%0d want 0 0 0", vn, fn, busy);
    end
    model_md = 32'h0;
  endtask

  initial begin
    test_reset();
    test_plan_loads();
    test_store();
    test_grant_delay();
    test_random();
`ifdef LSU_MISALIGN_TRAP_EN
    test_trap();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit of the RV32I core; sits between execute and writeback.
- Takes an ALU-computed address, store data and funct3 from EX.
- Runs a request/grant/response transaction on the data-memory bus.
- Returns aligned, sign- or zero-extended load data as mem_data to the writeback select. Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- RESP_LAT_MAX, 16, cycles allowed between grant and response before a bus error (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents a memory op this cycle
- mem_read  in  1  op is a load
- mem_write  in  1  op is a store (mem_read and mem_write never both 1)
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result  in  32  byte address
- store_data  in  32  rs2 value
- stall  out  1  freeze IF/ID/EX while the unit is busy
- mem_data  out  32  extended load result to writeback
- mem_valid  out  1  one-cycle pulse: op complete
- fault  out  1  one-cycle pulse: misaligned access or bus error
- dmem_req  out  1  bus request
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0
- dmem_wdata  out  32  lane-shifted store data
- dmem_wstrb  out  4  byte strobes
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response valid (load data or store ack)
- dmem_rdata  in  32  load word

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. All outputs read 0, and mem_data reads 0x00000000.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - ex_valid & (mem_read|mem_write) latches addr, funct3, rd/wr and the shifted data, then goes to REQ.
  - Otherwise the unit stays in IDLE and stall=0.
- REQ:
  - dmem_req=1. dmem_addr, dmem_we, dmem_wdata and dmem_wstrb stay stable until dmem_gnt=1.
  - On gnt the unit goes to RESP, and dmem_req drops the next cycle.
- RESP: waits for dmem_rvalid. On rvalid:
  - Loads capture and extend rdata.
  - The unit goes to DONE.
- DONE:
  - mem_valid=1 for exactly one cycle.
  - mem_data holds the new value from this cycle until the next load completes; stores do not change mem_data.
  - The unit returns to IDLE.
- stall=1 in REQ, RESP and IDLE-with-new-op; stall=0 in DONE and plain IDLE.
- Minimum latency: op in IDLE at cycle 0, gnt at cycle 1, rvalid at cycle 2, mem_valid at cycle 3.
- dmem_rvalid in the same cycle as dmem_gnt is legal: the unit goes straight REQ->DONE.
- ex_valid is ignored in every state except IDLE.
- Lanes use off = addr[1:0].
  - Store B: wstrb = 0001<<off, wdata = {4{byte}}.
  - Store H: wstrb = 0011<<off, wdata = {2{half}}.
  - Store W: wstrb = 1111.
  - Load: byte/half taken from rdata >> (8*off).
  - B and H are sign-extended from bit 7 / 15; BU and HU are zero-extended.
- Misalignment: H with off[0]=1, or W with off≠0.
- Undefined funct3 values (011, 110, 111) are handled as W.
- Reset asserted mid-transaction abandons it with no mem_valid and no fault. A late dmem_rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned op issues no bus request.
  - The unit goes IDLE->DONE with fault=1 and mem_valid=1, and mem_data is left unchanged.
  - A counter also runs in RESP. After RESP_LAT_MAX cycles without rvalid, the unit goes to DONE with fault=1.
- Undefined:
  - fault is tied to 0 and there is no timeout.
  - Misaligned addresses go out with offending low bits treated as the aligned offset, i.e. H at off=3 uses bytes 3 and 2 wrapped as off=2.
  - RESP waits indefinitely.

Test Plan:
- LB at addr 0x103, rdata 0x80FF_FF00, gnt same cycle as req, rvalid next cycle -> mem_data=0xFFFFFF80, mem_valid pulses at cycle 3, stall high for cycles 0-2.
- LHU at addr 0x102, rdata 0x8001_1234 -> mem_data=0x00008001. LH at the same address -> 0xFFFF8001.
- SB at addr 0x201 of 0x123456AB -> dmem_addr=0x200, wstrb=0010, wdata=0xABABABAB, dmem_we=1. mem_data is unchanged afterwards.
- Grant delayed 4 cycles -> dmem_addr/wstrb/wdata stay stable throughout REQ and dmem_req drops the cycle after gnt. A gnt and rvalid in the same cycle gives mem_valid one cycle later.
- rst asserted while in RESP, then rvalid arrives -> no mem_valid and no fault, all outputs 0, state IDLE.
- With LSU_MISALIGN_TRAP_EN: LW at 0x102 -> no dmem_req, fault=1 and mem_valid=1 one cycle later. No rvalid for 16 cycles in RESP -> fault pulses.
